// File: rtl/mac_tx_axis_arbiter_if.sv
// mac_tx_axis_arbiter_if: AXI-Stream bundle carrying N parallel lanes.
// One shared ready vector per lane; N=1 gives a plain single stream.
interface mac_tx_axis_arbiter_if #(
  parameter int N = 1,
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL = 8
);
  logic [N-1:0] tvalid;
  logic [N*N_SYMBOLS*W_SYMBOL-1:0] tdata;
  logic [N*N_SYMBOLS-1:0] tkeep;
  logic [N-1:0] tlast;
  logic [N-1:0] tready;
  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/mac_tx_axis_arbiter.sv
// mac_tx_axis_arbiter: frame-granular round-robin N-port AXI-Stream arbiter with registered output.
// Define ARB_STRICT_PRIORITY_EN to grant the lowest-index requester instead of round-robin.
module mac_tx_axis_arbiter #(
  parameter int N_PORTS = 4,
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL = 8,
  parameter int W_IDX = N_PORTS > 1 ? $clog2(N_PORTS) : 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clk_en,
  mac_tx_axis_arbiter_if.slave s_axis,
  mac_tx_axis_arbiter_if.master m_axis,
  output logic [W_IDX-1:0] o_grant,
  output logic o_active
);
  localparam int W_BEAT = N_SYMBOLS * W_SYMBOL;
  typedef enum logic {IDLE, FORWARD} state_t;
  state_t state, state_next;
  logic [W_IDX-1:0] grant_next, base, idx;
  logic ready, in_fire;
`ifdef ARB_STRICT_PRIORITY_EN
  assign base = W_IDX'(N_PORTS - 1);
`else
  logic [W_IDX-1:0] last_grant;
  assign base = last_grant;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) last_grant <= W_IDX'(N_PORTS - 1);
    else if (i_clk_en && state == IDLE && |s_axis.tvalid) last_grant <= grant_next;
`endif
  assign o_active = state == FORWARD;
  assign ready = o_active && i_clk_en && (!m_axis.tvalid[0] || m_axis.tready[0]);
  assign s_axis.tready = ready ? N_PORTS'(1) << o_grant : '0;
  assign in_fire = ready && s_axis.tvalid[o_grant];
  // scan downwards so the port closest after base wins
  always_comb begin
    grant_next = o_grant;
    idx = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      idx = W_IDX'((int'(base) + k) % N_PORTS);
      if (s_axis.tvalid[idx]) grant_next = idx;
    end
    state_next = (state == IDLE) ? (|s_axis.tvalid ? FORWARD : IDLE)
                                 : ((in_fire && s_axis.tlast[o_grant]) ? IDLE : FORWARD);
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      o_grant <= '0;
    end else if (i_clk_en) begin
      state <= state_next;
      if (state == IDLE) o_grant <= grant_next;
    end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      m_axis.tvalid <= '0;
      m_axis.tdata <= '0;
      m_axis.tkeep <= '0;
      m_axis.tlast <= '0;
    end else if (in_fire) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata <= s_axis.tdata[int'(o_grant)*W_BEAT +: W_BEAT];
      m_axis.tkeep <= s_axis.tkeep[int'(o_grant)*N_SYMBOLS +: N_SYMBOLS];
      m_axis.tlast <= s_axis.tlast[o_grant];
    end else if (i_clk_en && m_axis.tready[0]) begin
      m_axis.tvalid <= '0;
    end
endmodule
